// File: rtl/load_store_unit.sv
// Byte-serial RV32I load/store sequencer between the execute stage and a byte-wide data memory.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/HU/W requests respond with resp_err instead of running.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wd,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_STORE, S_LOAD, S_DRAIN, S_RESP, S_ERR
  } state_t;

  state_t                state, state_nxt;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [XLEN-1:0]       asm_q;
  logic [XLEN-1:0]       ext;
  logic [1:0]            cnt_q;
  logic [1:0]            last_idx;
  logic                  cap_vld_q;
  logic [1:0]            cap_idx_q;
  logic                  accept;
  logic                  bad;
  logic                  last_byte;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high exactly in IDLE and never depends on req_valid.
  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign last_idx  = (funct3_q[1:0] == 2'b00) ? 2'd0 :
                     (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign last_byte = (cnt_q == last_idx);
  assign cur_addr  = addr_q + ADDR_WIDTH'(cnt_q);

  always_comb begin
    bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
          (req_we && req_funct3[2]);
`ifdef MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) bad = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) bad = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = bad ? S_ERR : (req_we ? S_STORE : S_LOAD);
      S_STORE: if (last_byte) state_nxt = S_RESP;
      S_LOAD:  if (last_byte) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data returns one cycle after its strobe, so the capture slot trails the issue counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      asm_q     <= '0;
      cnt_q     <= 2'd0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= 2'd0;
    end else begin
      cap_vld_q <= (state == S_LOAD);
      cap_idx_q <= cnt_q;
      if (cap_vld_q) asm_q[{cap_idx_q, 3'b000} +: 8] <= mem_data_out;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        asm_q    <= '0;
        cnt_q    <= 2'd0;
      end else if (state == S_STORE || state == S_LOAD) begin
        cnt_q <= last_byte ? 2'd0 : cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    case (funct3_q)
      3'b000:  ext = {{24{asm_q[7]}}, asm_q[7:0]};
      3'b001:  ext = {{16{asm_q[15]}}, asm_q[15:0]};
      3'b100:  ext = {24'd0, asm_q[7:0]};
      3'b101:  ext = {16'd0, asm_q[15:0]};
      default: ext = asm_q;
    endcase
  end

  always_comb begin
    mem_wd       = 1'b0;
    mem_rd       = 1'b0;
    mem_addr_in  = '0;
    mem_addr_out = '0;
    mem_data_in  = 8'd0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    resp_rdata   = '0;
    case (state)
      S_STORE: begin
        mem_wd       = 1'b1;
        mem_addr_in  = cur_addr;
        mem_addr_out = cur_addr;
        mem_data_in  = wdata_q[{cnt_q, 3'b000} +: 8];
      end
      S_LOAD: begin
        mem_rd       = 1'b1;
        mem_addr_in  = cur_addr;
        mem_addr_out = cur_addr;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = we_q ? '0 : ext;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Byte-serial load/store sequencer between the core's execute stage and the byte-wide data memory (8-bit word, 16-bit address, registered read with 1-cycle latency).
- Accepts one 32-bit RV32I load/store request at a time.
- Splits the request into 1, 2 or 4 little-endian byte accesses on the memory port.
- Assembles and sign/zero-extends load data.
- Returns a single-cycle response.

Parameters:
ADDR_WIDTH, 16, byte address width; matches the data memory address width.
XLEN, 32, core data width; fixed at 32 (4 bytes max per access).

Ports:
clk  input  1  clock; all state updates on the posedge
reset  input  1  asynchronous, active-high; forces IDLE
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; a request is accepted on a posedge where req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
req_addr  input  ADDR_WIDTH  byte address of the access
req_wdata  input  XLEN  store data; low bytes used for B/H
resp_valid  output  1  one-cycle pulse on completion
resp_rdata  output  XLEN  extended load data; 0 for stores and errors
resp_err  output  1  qualifies resp_valid; illegal funct3 (or misaligned access when the macro is enabled)
mem_wd  output  1  memory write strobe
mem_rd  output  1  memory read strobe
mem_addr_in  output  ADDR_WIDTH  memory write address
mem_addr_out  output  ADDR_WIDTH  memory read address
mem_data_in  output  8  memory write byte
mem_data_out  input  8  memory read byte; valid the cycle after mem_rd

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high.
- Reset values: state=IDLE, byte counter=0, mem_wd=0, mem_rd=0, mem_addr_in=0, mem_addr_out=0, mem_data_in=0, resp_valid=0, resp_rdata=0, resp_err=0, assembly register=0. req_ready=1 whenever the state is IDLE.
- Accept: on acceptance, latch we, funct3, addr and wdata. Byte count n = 1 (B/BU), 2 (H/HU), 4 (W).
- Illegal funct3: 011, 110 and 111 for any request; 100 and 101 for stores.
- Byte addressing: byte i is at (addr + i) mod 2^ADDR_WIDTH, so addresses wrap at the top of memory. mem_addr_in and mem_addr_out both carry the current byte address; only the strobes differ.
- States:
  - IDLE: no strobes.
    - Accepted illegal request -> ERR.
    - Accepted store -> STORE.
    - Accepted load -> LOAD.
  - STORE: cycles 1..n after acceptance. Assert mem_wd with mem_data_in = wdata byte i. After byte n-1 -> RESP.
  - LOAD: cycles 1..n. Assert mem_rd for byte i. mem_data_out is captured into assembly byte i-1 in the cycle after each issue. After the issue of byte n-1 -> DRAIN.
  - DRAIN: one cycle, no strobes; capture byte n-1 -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, resp_err=0, then -> IDLE. For loads, resp_rdata is bits [8n-1:0] of the assembly register, extended to 32 bits:
    - Sign-extended for B/H.
    - Zero-extended for BU/HU.
    - Unchanged for W.
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, no memory strobes, then -> IDLE.
- Latency from acceptance edge to resp_valid: store n+1 cycles; load n+2 cycles; error 1 cycle.
- Back-to-back: the next request can be accepted in the cycle after RESP/ERR.
- Strobe exclusivity: mem_wd and mem_rd are never high together.
- Response pulse: resp_valid is never high for two consecutive cycles. There is no response backpressure; the consumer must sample on the pulse.
- Input stability: req_* may change freely after acceptance; the latched copies are used.
- Reset mid-operation: the sequence is abandoned and no response is produced. Bytes already written stay written. The assembly register clears.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: H/HU requests with addr[0]≠0, and W requests with addr[1:0]≠0, go to ERR (resp_err=1, no memory strobes).
- Undefined: misaligned accesses proceed byte-serially with address wrap-around, same timing as aligned accesses.

Test Plan:
- SW addr 0x0010, wdata 0xDEADBEEF -> mem_wd in cycles 1-4 with bytes 0xEF, 0xBE, 0xAD, 0xDE at 0x0010-0x0013. resp_valid in cycle 5, resp_err=0, resp_rdata=0.
- After the store: LB 0x0013 -> 0xFFFFFFDE. LBU 0x0013 -> 0x000000DE. LH 0x0012 -> 0xFFFFDEAD. LW 0x0010 -> 0xDEADBEEF with resp_valid in cycle 6. mem_rd never overlaps mem_wd.
- funct3=011 load, and funct3=100 store -> resp_valid and resp_err=1 one cycle after acceptance, resp_rdata=0, no strobes.
- SH addr 0xFFFF, wdata 0x00001234:
  - Macro undefined: 0x34 written at 0xFFFF, 0x12 at 0x0000, resp_err=0.
  - Macro defined: resp_err=1 and memory unchanged.
- Assert reset after the second mem_wd of SW 0x0020, wdata 0x11223344 -> no resp_valid, req_ready=1 immediately. Memory holds 0x44, 0x33 at 0x0020-0x0021; 0x0022-0x0023 unchanged.
- req_valid held high for LW then SW back-to-back -> second request accepted the cycle after the first resp_valid. req_ready=0 throughout both sequences.
